// File: rtl/axi_lite_master.sv
// Single-outstanding AXI-Lite master: turns one core request at a time into an
// AXI-Lite write or read, with an optional per-transaction timeout.
module axi_lite_master #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [31:0] axi_awaddr_o,
    output logic        axi_awvalid_o,
    input  logic        axi_awready_i,
    output logic [31:0] axi_wdata_o,
    output logic        axi_wvalid_o,
    input  logic        axi_wready_i,
    input  logic        axi_bvalid_i,
    output logic        axi_bready_o,
    output logic [31:0] axi_araddr_o,
    output logic        axi_arvalid_o,
    input  logic        axi_arready_i,
    input  logic [31:0] axi_rdata_i,
    input  logic        axi_rvalid_i,
    output logic        axi_rready_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '0;

    typedef enum logic [2:0] {
        IDLE,
        WR_AW_W,
        WR_B,
        RD_AR,
        RD_R
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_awvalid;
    logic             r_wvalid;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [31:0]      r_rdata;
    logic             r_rsp_valid;
    logic             r_rsp_err;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_accept;
    logic             w_aw_hs;
    logic             w_w_hs;
    logic             w_wr_done;
    logic             w_rd_done;
    logic             w_complete;
    logic             w_timeout;

    assign w_accept   = req_valid_i && (r_state == IDLE);
    assign w_aw_hs    = r_awvalid && axi_awready_i;
    assign w_w_hs     = r_wvalid && axi_wready_i;
    assign w_wr_done  = (r_state == WR_B) && axi_bvalid_i;
    assign w_rd_done  = (r_state == RD_R) && axi_rvalid_i;
    assign w_complete = w_wr_done || w_rd_done;
    assign w_cnt_inc  = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // The timeout fires in the TIMEOUT-th busy cycle, i.e. when that cycle's
    // increment brings the counter to TIMEOUT; a completion in it still wins.
    assign w_timeout = (TIMEOUT > 0) && (r_state != IDLE) &&
                       (w_cnt_inc == CNT_MAX) && !w_complete;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid_i) begin
                    w_next = req_we_i ? WR_AW_W : RD_AR;
                end
            end
            WR_AW_W: begin
                if (w_timeout) begin
                    w_next = IDLE;
                end else if ((!r_awvalid || w_aw_hs) && (!r_wvalid || w_w_hs)) begin
                    w_next = WR_B;
                end
            end
            WR_B: begin
                if (w_wr_done || w_timeout) begin
                    w_next = IDLE;
                end
            end
            RD_AR: begin
                if (w_timeout) begin
                    w_next = IDLE;
                end else if (axi_arready_i) begin
                    w_next = RD_R;
                end
            end
            RD_R: begin
                if (w_rd_done || w_timeout) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_rsp_valid <= w_complete || w_timeout;
            r_rsp_err   <= w_timeout;
            if (w_accept) begin
                r_addr  <= req_addr_i;
                r_wdata <= req_wdata_i;
                r_cnt   <= '0;
            end else if (r_state != IDLE) begin
                r_cnt <= w_cnt_inc;
            end
            // AW and W channels retire independently of each other
            if (w_accept && req_we_i) begin
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
            end else begin
                if (w_aw_hs || w_timeout) r_awvalid <= 1'b0;
                if (w_w_hs || w_timeout)  r_wvalid  <= 1'b0;
            end
            if (w_rd_done) begin
                r_rdata <= axi_rdata_i;
            end
        end
    end

    assign req_ready_o   = (r_state == IDLE);
    assign rsp_valid_o   = r_rsp_valid;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_rdata_o   = r_rdata;
    assign axi_awaddr_o  = r_addr;
    assign axi_awvalid_o = r_awvalid;
    assign axi_wdata_o   = r_wdata;
    assign axi_wvalid_o  = r_wvalid;
    assign axi_bready_o  = (r_state == WR_B);
    assign axi_araddr_o  = r_addr;
    assign axi_arvalid_o = (r_state == RD_AR);
    assign axi_rready_o  = (r_state == RD_R);

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: writes, reads, stalled AW, timeout,
// completion-vs-timeout priority, mid-transaction reset and back-to-back requests.
module tb_axi_lite_master;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        rready;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    axi_lite_master #(.TIMEOUT(TIMEOUT)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_err_o     (rsp_err),
        .axi_awaddr_o  (awaddr),
        .axi_awvalid_o (awvalid),
        .axi_awready_i (awready),
        .axi_wdata_o   (wdata),
        .axi_wvalid_o  (wvalid),
        .axi_wready_i  (wready),
        .axi_bvalid_i  (bvalid),
        .axi_bready_o  (bready),
        .axi_araddr_o  (araddr),
        .axi_arvalid_o (arvalid),
        .axi_arready_i (arready),
        .axi_rdata_i   (rdata),
        .axi_rvalid_i  (rvalid),
        .axi_rready_o  (rready)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic req(input logic we, input logic [31:0] addr, input logic [31:0] data);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int early;
        rst = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        arready = 1'b0; rdata = '0; rvalid = 1'b0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_req_ready", req_ready, 1);
        chk("rst_awvalid",   awvalid,   0);
        chk("rst_wvalid",    wvalid,    0);
        chk("rst_arvalid",   arvalid,   0);
        chk("rst_bready",    bready,    0);
        chk("rst_rready",    rready,    0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err",   rsp_err,   0);
        chk("rst_rdata",     rsp_rdata, 0);
        chk("rst_awaddr",    awaddr,    0);
        rst = 1'b0;

        // write 0xDEADBEEF to 0x10, always-ready slave, B one cycle later
        awready = 1'b1; wready = 1'b1;
        req(1'b1, 32'h10, 32'hDEADBEEF);
        @(negedge clk);
        chk("wr_awvalid",   awvalid,   1);
        chk("wr_wvalid",    wvalid,    1);
        chk("wr_awaddr",    awaddr,    32'h10);
        chk("wr_wdata",     wdata,     32'hDEADBEEF);
        chk("wr_req_ready", req_ready, 0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("wr_aw_drop",   awvalid,   0);
        chk("wr_w_drop",    wvalid,    0);
        chk("wr_bready",    bready,    1);
        chk("wr_no_rsp",    rsp_valid, 0);
        bvalid = 1'b1;
        @(negedge clk);
        chk("wr_rsp_valid", rsp_valid, 1);
        chk("wr_rsp_err",   rsp_err,   0);
        chk("wr_idle",      req_ready, 1);
        chk("wr_bready_lo", bready,    0);
        bvalid = 1'b0;
        @(negedge clk);
        chk("wr_rsp_pulse", rsp_valid, 0);

        // read 0x10 back
        arready = 1'b1;
        req(1'b0, 32'h10, 32'h0);
        @(negedge clk);
        chk("rd_arvalid", arvalid, 1);
        chk("rd_araddr",  araddr,  32'h10);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rd_ar_drop", arvalid, 0);
        chk("rd_rready",  rready,  1);
        rvalid = 1'b1; rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_err",   rsp_err,   0);
        chk("rd_rdata",     rsp_rdata, 32'hDEADBEEF);
        rvalid = 1'b0; rdata = 32'h0;

        // AW stalled three cycles, W accepted immediately
        awready = 1'b0; wready = 1'b1;
        req(1'b1, 32'h20, 32'h12345678);
        @(negedge clk);
        chk("awd_awvalid1", awvalid, 1);
        chk("awd_wvalid1",  wvalid,  1);
        req_valid = 1'b0;
        @(negedge clk);
        chk("awd_w_drop",   wvalid,  0);
        chk("awd_awvalid2", awvalid, 1);
        @(negedge clk);
        chk("awd_awvalid3", awvalid, 1);
        chk("awd_no_bready", bready, 0);
        @(negedge clk);
        chk("awd_awvalid4", awvalid, 1);
        awready = 1'b1;
        @(negedge clk);
        chk("awd_aw_drop", awvalid, 0);
        chk("awd_bready",  bready,  1);
        bvalid = 1'b1;
        @(negedge clk);
        chk("awd_rsp_valid", rsp_valid, 1);
        chk("awd_rsp_err",   rsp_err,   0);
        chk("awd_rdata_kept", rsp_rdata, 32'hDEADBEEF);
        bvalid = 1'b0;
        @(negedge clk);
        chk("awd_single_rsp", rsp_valid, 0);

        // read that never gets rvalid: response after TIMEOUT busy cycles
        arready = 1'b1;
        req(1'b0, 32'h30, 32'h0);
        cyc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) begin
                cyc = i;
                break;
            end
        end
        // first negedge follows the accepting edge, so the pulse is seen at TIMEOUT+1
        chk("to_latency",   cyc,       TIMEOUT + 1);
        chk("to_rsp_err",   rsp_err,   1);
        chk("to_rready",    rready,    0);
        chk("to_req_ready", req_ready, 1);
        chk("to_rdata_kept", rsp_rdata, 32'hDEADBEEF);
        @(negedge clk);
        chk("to_rsp_pulse", rsp_valid, 0);
        chk("to_err_clear", rsp_err,   0);

        // rvalid arrives in the very cycle the timeout would fire
        req(1'b0, 32'h40, 32'h0);
        early = 0;
        for (int i = 1; i <= TIMEOUT; i++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (rsp_valid) early++;
        end
        rvalid = 1'b1; rdata = 32'hA5A50001;
        @(negedge clk);
        chk("pri_no_early", early,     0);
        chk("pri_rsp_valid", rsp_valid, 1);
        chk("pri_rsp_err",   rsp_err,   0);
        chk("pri_rdata",     rsp_rdata, 32'hA5A50001);
        rvalid = 1'b0; rdata = 32'h0;

        // reset asserted while waiting in WR_B
        awready = 1'b1; wready = 1'b1;
        req(1'b1, 32'h70, 32'h00000077);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstb_bready", bready, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstb_bready_lo", bready,    0);
        chk("rstb_req_ready", req_ready, 1);
        chk("rstb_awaddr",    awaddr,    0);
        chk("rstb_wdata",     wdata,     0);
        chk("rstb_rdata",     rsp_rdata, 0);
        chk("rstb_rsp_valid", rsp_valid, 0);
        bvalid = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        early = 0;
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid) early++;
        end
        chk("rstb_stray_b_ignored", early, 0);
        bvalid = 1'b0;
        arready = 1'b1;
        req(1'b0, 32'h80, 32'h0);
        @(negedge clk);
        chk("rstb_rd_araddr", araddr, 32'h80);
        req_valid = 1'b0;
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("rstb_rd_rsp",   rsp_valid, 1);
        chk("rstb_rd_err",   rsp_err,   0);
        chk("rstb_rd_rdata", rsp_rdata, 32'hCAFEF00D);
        rvalid = 1'b0; rdata = 32'h0;

        // back-to-back read then write with req_valid held high
        req(1'b0, 32'h50, 32'h0);
        @(negedge clk);
        chk("b2b_arvalid", arvalid, 1);
        req(1'b1, 32'h60, 32'h0BADCAFE);
        @(negedge clk);
        rvalid = 1'b1; rdata = 32'h11112222;
        @(negedge clk);
        chk("b2b_rsp1",       rsp_valid, 1);
        chk("b2b_ready_rsp1", req_ready, 1);
        chk("b2b_rdata1",     rsp_rdata, 32'h11112222);
        rvalid = 1'b0; rdata = 32'h0;
        @(negedge clk);
        chk("b2b_wr_accepted", awvalid, 1);
        chk("b2b_wvalid",      wvalid,  1);
        chk("b2b_awaddr",      awaddr,  32'h60);
        chk("b2b_wdata",       wdata,   32'h0BADCAFE);
        req_valid = 1'b0;
        @(negedge clk);
        bvalid = 1'b1;
        @(negedge clk);
        chk("b2b_rsp2",       rsp_valid, 1);
        chk("b2b_rsp2_err",   rsp_err,   0);
        chk("b2b_rdata_kept", rsp_rdata, 32'h11112222);
        bvalid = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
